// File: rtl/video_timing_ctrl.sv
// Video timing controller: h/v counters, undelayed pixel requests, delayed sync/de.
// Latency: o_req/o_x/o_y/o_frame_start undelayed; o_hsync/o_vsync/o_de lag by PIPE_DELAY cycles.
// Backpressure: none; start/stop honoured only on frame boundaries, reset truncates immediately.
//
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   i_enable          level request for video output
//   o_running         high while running or draining the current frame
//   o_x, o_y          current h/v counters (undelayed)
//   o_req             undelayed pixel request for the active area
//   o_frame_start     one-cycle pulse at h == 0, v == 0 while running
//   o_hsync, o_vsync  sync outputs, delayed, polarity per HS_POL/VS_POL
//   o_de              o_req delayed by PIPE_DELAY cycles
module video_timing_ctrl #(
   parameter int H_ACTIVE   = 1280,
   parameter int H_FP       = 110,
   parameter int H_SYNC     = 40,
   parameter int H_BP       = 220,
   parameter int V_ACTIVE   = 720,
   parameter int V_FP       = 5,
   parameter int V_SYNC     = 5,
   parameter int V_BP       = 20,
   parameter bit HS_POL     = 1'b1,
   parameter bit VS_POL     = 1'b1,
   parameter int PIPE_DELAY = 2,
   parameter int CNT_BITS   = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_enable,
   output logic                o_running,
   output logic [CNT_BITS-1:0] o_x,
   output logic [CNT_BITS-1:0] o_y,
   output logic                o_req,
   output logic                o_frame_start,
   output logic                o_hsync,
   output logic                o_vsync,
   output logic                o_de
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
   localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] H_LAST   = CNT_BITS'(H_TOTAL - 1);
   localparam logic [CNT_BITS-1:0] V_LAST   = CNT_BITS'(V_TOTAL - 1);
   localparam logic [CNT_BITS-1:0] H_ACT    = CNT_BITS'(H_ACTIVE);
   localparam logic [CNT_BITS-1:0] V_ACT    = CNT_BITS'(V_ACTIVE);
   localparam logic [CNT_BITS-1:0] HS_START = CNT_BITS'(H_ACTIVE + H_FP);
   localparam logic [CNT_BITS-1:0] HS_END   = CNT_BITS'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_BITS-1:0] VS_START = CNT_BITS'(V_ACTIVE + V_FP);
   localparam logic [CNT_BITS-1:0] VS_END   = CNT_BITS'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_BITS-1:0] h_q, h_d;
   logic [CNT_BITS-1:0] v_q, v_d;
   logic                running;
   logic                line_end;
   logic                frame_end;
   logic                hs_raw;
   logic                vs_raw;
   logic                req_raw;
   logic [2:0]          raw_vec;   // {hsync, vsync, req}, active-high
   logic [2:0]          dly_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         h_q     <= CNT_ZERO;
         v_q     <= CNT_ZERO;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      h_d       = h_q;
      v_d       = v_q;
      running   = (state_q != ST_IDLE);
      line_end  = (h_q == H_LAST);
      frame_end = line_end && (v_q == V_LAST);

      // RUN and DRAIN count identically; the last cycle of a frame wraps both
      // counters to zero, which is also the IDLE value when draining ends.
      if (running) begin
         if (line_end) begin
            h_d = CNT_ZERO;
            v_d = (v_q == V_LAST) ? CNT_ZERO : v_q + CNT_ONE;
         end else begin
            h_d = h_q + CNT_ONE;
         end
      end

      case (state_q)
         ST_IDLE: begin
            h_d = CNT_ZERO;
            v_d = CNT_ZERO;
            if (i_enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!i_enable) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // A returning enable wins, so re-enabling on the final cycle keeps streaming.
            if (i_enable)       state_d = ST_RUN;
            else if (frame_end) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            h_d     = CNT_ZERO;
            v_d     = CNT_ZERO;
         end
      endcase
   end

   assign req_raw = running && (h_q < H_ACT) && (v_q < V_ACT);
   assign hs_raw  = running && (h_q >= HS_START) && (h_q < HS_END);
   assign vs_raw  = running && (v_q >= VS_START) && (v_q < VS_END);
   assign raw_vec = {hs_raw, vs_raw, req_raw};

   generate
      if (PIPE_DELAY == 0) begin : g_nodly
         assign dly_out = raw_vec;
      end else begin : g_dly
         logic [2:0] pipe_q [PIPE_DELAY];

         // Reset clears every stage so no stale sync/de leaks out after rst.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= 3'b000;
            end else begin
               pipe_q[0] <= raw_vec;
               for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign dly_out = pipe_q[PIPE_DELAY-1];
      end
   endgenerate

   assign o_running     = running;
   assign o_x           = h_q;
   assign o_y           = v_q;
   assign o_req         = req_raw;
   assign o_frame_start = running && (h_q == CNT_ZERO) && (v_q == CNT_ZERO);
   assign o_hsync       = dly_out[2] ? HS_POL : ~HS_POL;
   assign o_vsync       = dly_out[1] ? VS_POL : ~VS_POL;
   assign o_de          = dly_out[0];

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
Sequences the HDMI output pixel path. Runs horizontal/vertical counters for a programmable video mode and issues undelayed pixel requests/coordinates to the upstream pixel source. Emits hsync/vsync/de through an internal delay line of PIPE_DELAY cycles so sync/de arrive aligned with pixels that have crossed the downstream pixel pipeline. Supports clean start/stop at frame boundaries only.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, hsync width (pixels)
H_BP, 220, horizontal back porch (pixels)
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines)
HS_POL, 1, hsync active level (1 = active-high)
VS_POL, 1, vsync active level
PIPE_DELAY, 2, downstream pixel latency in cycles; 0 = no delay, any value >= 0 legal
CNT_BITS, 12, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
i_enable  in  1  level; request video output
o_running  out  1  1 while state is RUN or DRAIN
o_x  out  CNT_BITS  current h counter (undelayed)
o_y  out  CNT_BITS  current v counter (undelayed)
o_req  out  1  undelayed pixel request: running && h < H_ACTIVE && v < V_ACTIVE
o_frame_start  out  1  one-cycle pulse when running && h == 0 && v == 0
o_hsync  out  1  hsync, delayed PIPE_DELAY cycles, polarity HS_POL
o_vsync  out  1  vsync, delayed PIPE_DELAY cycles, polarity VS_POL
o_de  out  1  o_req delayed PIPE_DELAY cycles

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Line order: active, FP, sync, BP. Same order for lines within a frame.
- Reset (any cycle, including mid-frame): state IDLE; h = v = 0; o_running, o_req, o_frame_start, o_de = 0; o_hsync = !HS_POL; o_vsync = !VS_POL. All delay-line stages load inactive values, so no stale sync/de emerges after reset.
- States:
  - IDLE: counters held at 0; o_req = 0; delay-line input is inactive levels. i_enable = 1 -> RUN next cycle. h = v = 0 in that cycle, so o_req and o_frame_start are 1 one cycle after i_enable is first sampled high.
  - RUN: h increments every cycle. At h == H_TOTAL-1, h wraps to 0 and v increments; at v == V_TOTAL-1 on that wrap, v wraps to 0. i_enable = 0 -> DRAIN.
  - DRAIN: counts exactly as RUN. At h == H_TOTAL-1 && v == V_TOTAL-1, go to IDLE (counters 0). If i_enable returns to 1 first, go back to RUN with no counter disturbance.
- Stopping happens only after the last cycle of a complete frame; frames are never truncated except by rst.
- hsync_raw active when running && H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vsync_raw active when running && V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. It changes with v, i.e. at h = 0.
- Delay line: {hsync_raw, vsync_raw, o_req} shifted PIPE_DELAY registers. o_hsync/o_vsync/o_de at cycle t equal raw values at t-PIPE_DELAY. PIPE_DELAY = 0 gives a combinational pass-through.
- After entering IDLE, delayed outputs keep draining for PIPE_DELAY cycles, then hold inactive.
- All comparisons are unsigned at CNT_BITS width. Counters never exceed H_TOTAL-1 / V_TOTAL-1.

Test Plan:
Bench params: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), PIPE_DELAY 2, pols 1. Frame = 48 cycles.
1. Start: rst 2 cycles, then i_enable = 1 at cycle 0 -> cycle 1: o_frame_start = 1, o_req = 1, o_x = 0, o_y = 0. o_de first 1 at cycle 3 and stays 1 for cycles 3..6.
2. Line timing: in RUN -> o_req high for o_x 0..3 on lines 0..2. o_hsync = 1 for exactly 2 cycles per line, 2 cycles after raw h = 5,6. No o_req on lines 3..5. o_vsync high for line 4 only (8 cycles), delayed 2.
3. Stop: i_enable dropped at frame cycle 10 -> o_running stays 1 until the frame's 48th cycle completes, then 0. Next frame_start never occurs. o_de/o_hsync inactive after 2 more cycles.
4. Re-enable in DRAIN: drop i_enable at cycle 10, raise at cycle 20 -> no gap. o_frame_start pulses again 48 cycles after the first.
5. Reset mid-frame: assert rst at o_x = 2, o_y = 1 -> next cycle all outputs at reset values, including o_de = 0 (delay line flushed). Release with i_enable = 1 -> restarts at h = v = 0.
6. PIPE_DELAY = 0 build: o_de == o_req and sync equals raw on every cycle over two frames.
